// File: rtl/rotary_counter.sv
// rotary_counter: synchronised, debounced quadrature rotary encoder decoder with a wrapping or saturating position count
module rotary_counter #(
   parameter int CNT_W        = 8,
   parameter int DEBOUNCE_CYC = 4,
   parameter bit WRAP         = 1'b1,
   parameter int CNT_MIN      = 0,
   parameter int CNT_MAX      = 255,
   parameter int STEP         = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rot_a,
   input  logic             rot_b,
   input  logic             en,
   input  logic             clr,
   output logic             rot_event,
   output logic             rot_dir,
   output logic             step_pulse,
   output logic [CNT_W-1:0] count,
   output logic             at_limit
);
   localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
   localparam int EW = CNT_W + 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W:0] MIN_E = EW'(CNT_MIN);
   localparam logic [CNT_W:0] MAX_E = EW'(CNT_MAX);
   localparam logic [CNT_W:0] STEP_E = EW'(STEP);
   logic [1:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;
   logic [DW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic filt_a_q, filt_a_d, filt_b_q, filt_b_d;
   logic ev_q, ev_d, dir_q, dir_d, ev_dly_q, ev_dly_d, step_q, step_d;
   logic a_chg, b_chg;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W:0] cnt_e, up_e, dn_e, nxt_e;
   always_comb begin
      sync_a_d = {sync_a_q[0], rot_a};
      sync_b_d = {sync_b_q[0], rot_b};
      a_chg    = sync_a_q[1] != filt_a_q;
      b_chg    = sync_b_q[1] != filt_b_q;
      a_cnt_d  = (a_chg && a_cnt_q != DB_LAST) ? a_cnt_q + 1'b1 : '0;
      b_cnt_d  = (b_chg && b_cnt_q != DB_LAST) ? b_cnt_q + 1'b1 : '0;
      filt_a_d = (a_chg && a_cnt_q == DB_LAST) ? sync_a_q[1] : filt_a_q;
      filt_b_d = (b_chg && b_cnt_q == DB_LAST) ? sync_b_q[1] : filt_b_q;
      ev_d     = (filt_a_q & filt_b_q) ? 1'b1 : (~filt_a_q & ~filt_b_q) ? 1'b0 : ev_q;
      // a lone high channel names the direction: B alone means up
      dir_d    = (filt_a_q ^ filt_b_q) ? filt_b_q : dir_q;
      ev_dly_d = ev_q;
      step_d   = ev_q & ~ev_dly_q;
      cnt_e    = {1'b0, count_q};
      up_e     = cnt_e + STEP_E;
      dn_e     = cnt_e - STEP_E;
      nxt_e    = dir_q ? ((up_e > MAX_E) ? (WRAP ? MIN_E : MAX_E) : up_e)
                       : ((cnt_e < MIN_E + STEP_E) ? (WRAP ? MAX_E : MIN_E) : dn_e);
      count_d  = clr ? MIN_E[CNT_W-1:0] : (en & step_d) ? nxt_e[CNT_W-1:0] : count_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a_q <= '0;
         sync_b_q <= '0;
         a_cnt_q  <= '0;
         b_cnt_q  <= '0;
         filt_a_q <= 1'b0;
         filt_b_q <= 1'b0;
         ev_q     <= 1'b0;
         dir_q    <= 1'b0;
         ev_dly_q <= 1'b0;
         step_q   <= 1'b0;
         count_q  <= MIN_E[CNT_W-1:0];
      end else begin
         sync_a_q <= sync_a_d;
         sync_b_q <= sync_b_d;
         a_cnt_q  <= a_cnt_d;
         b_cnt_q  <= b_cnt_d;
         filt_a_q <= filt_a_d;
         filt_b_q <= filt_b_d;
         ev_q     <= ev_d;
         dir_q    <= dir_d;
         ev_dly_q <= ev_dly_d;
         step_q   <= step_d;
         count_q  <= count_d;
      end
   end
   assign rot_event  = ev_q;
   assign rot_dir    = dir_q;
   assign step_pulse = step_q;
   assign count      = count_q;
   assign at_limit   = (cnt_e == MIN_E) || (cnt_e == MAX_E);
endmodule

// File: tb/tb_rotary_counter.sv
// tb_rotary_counter: directed checks of rotary_counter in wrapping, saturating and coarse-step configurations
module tb_rotary_counter;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic rot_a = 1'b0, rot_b = 1'b0, en = 1'b1, clr = 1'b0;
   logic ev0, dir0, sp0, lim0, ev1, dir1, sp1, lim1, ev2, dir2, sp2, lim2;
   logic [7:0] cnt0, cnt1, cnt2;
   int total = 0, bad = 0, pulses = 0, snap = 0;
   always #5 clk = ~clk;
   rotary_counter u0 (
      .clk(clk), .rst_n(rst_n), .rot_a(rot_a), .rot_b(rot_b), .en(en), .clr(clr),
      .rot_event(ev0), .rot_dir(dir0), .step_pulse(sp0), .count(cnt0), .at_limit(lim0)
   );
   rotary_counter #(.WRAP(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .rot_a(rot_a), .rot_b(rot_b), .en(en), .clr(clr),
      .rot_event(ev1), .rot_dir(dir1), .step_pulse(sp1), .count(cnt1), .at_limit(lim1)
   );
   rotary_counter #(.WRAP(1'b0), .STEP(3), .CNT_MIN(2)) u2 (
      .clk(clk), .rst_n(rst_n), .rot_a(rot_a), .rot_b(rot_b), .en(en), .clr(clr),
      .rot_event(ev2), .rot_dir(dir2), .step_pulse(sp2), .count(cnt2), .at_limit(lim2)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      if (sp0) pulses++;
   endtask
   task automatic phase(input logic a, input logic b);
      rot_a = a;
      rot_b = b;
      repeat (10) tick();
   endtask
   task automatic cw(input int n);
      repeat (n) begin
         phase(1'b0, 1'b1);
         phase(1'b1, 1'b1);
         phase(1'b1, 1'b0);
         phase(1'b0, 1'b0);
      end
   endtask
   task automatic ccw(input int n);
      repeat (n) begin
         phase(1'b1, 1'b0);
         phase(1'b1, 1'b1);
         phase(1'b0, 1'b1);
         phase(1'b0, 1'b0);
      end
   endtask
   initial begin
      #2 rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_count", cnt0, 0);
      chk("rst_at_limit", lim0, 1);
      chk("rst_event", ev0, 0);
      chk("rst_dir", dir0, 0);
      chk("rst_step", sp0, 0);
      chk("rst_count_min2", cnt2, 2);
      rst_n = 1'b1;
      repeat (3) tick();
      pulses = 0;
      rot_b = 1'b1;
      repeat (6) tick();
      chk("dir_edge6", dir0, 0);
      tick();
      chk("dir_edge7", dir0, 1);
      repeat (3) tick();
      rot_a = 1'b1;
      repeat (6) tick();
      chk("event_edge6", ev0, 0);
      tick();
      chk("event_edge7", ev0, 1);
      chk("step_edge7", sp0, 0);
      chk("lim_edge7", lim0, 1);
      tick();
      chk("step_edge8", sp0, 1);
      chk("count_edge8", cnt0, 1);
      chk("lim_edge8", lim0, 0);
      tick();
      chk("step_edge9", sp0, 0);
      tick();
      phase(1'b1, 1'b0);
      phase(1'b0, 1'b0);
      cw(2);
      chk("cw3_count", cnt0, 3);
      chk("cw3_pulses", pulses, 3);
      ccw(3);
      chk("ccw3_count", cnt0, 0);
      chk("ccw3_count_min2", cnt2, 2);
      chk("ccw3_lim", lim0, 1);
      snap = pulses;
      rot_a = 1'b1;
      repeat (3) tick();
      rot_a = 1'b0;
      repeat (12) tick();
      chk("glitch_dir", dir0, 1);
      chk("glitch_event", ev0, 0);
      chk("glitch_count", cnt0, 0);
      chk("glitch_pulses", pulses - snap, 0);
      ccw(1);
      chk("wrap_down", cnt0, 255);
      chk("wrap_down_lim", lim0, 1);
      chk("sat_down", cnt1, 0);
      cw(1);
      chk("wrap_up", cnt0, 0);
      chk("sat_cnt_after_up", cnt1, 1);
      cw(83);
      chk("step3_pre", cnt2, 254);
      chk("step3_pre_lim", lim2, 0);
      cw(1);
      chk("step3_sat", cnt2, 255);
      chk("step3_sat_lim", lim2, 1);
      cw(170);
      chk("sat_reach", cnt1, 255);
      cw(3);
      chk("sat_hold", cnt1, 255);
      chk("sat_hold_lim", lim1, 1);
      chk("wrap_long", cnt0, 1);
      phase(1'b0, 1'b1);
      rot_a = 1'b1;
      repeat (7) tick();
      clr = 1'b1;
      tick();
      chk("clr_step", sp0, 1);
      chk("clr_count_wrap", cnt0, 0);
      chk("clr_count_sat", cnt1, 0);
      chk("clr_count_min2", cnt2, 2);
      clr = 1'b0;
      repeat (2) tick();
      phase(1'b1, 1'b0);
      phase(1'b0, 1'b0);
      en = 1'b0;
      snap = pulses;
      cw(2);
      chk("en0_pulses", pulses - snap, 2);
      chk("en0_count", cnt0, 0);
      chk("en0_count_min2", cnt2, 2);
      en = 1'b1;
      cw(4);
      phase(1'b0, 1'b1);
      rot_a = 1'b1;
      repeat (10) tick();
      chk("pre_rst_count", cnt0, 5);
      chk("pre_rst_event", ev0, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_count", cnt0, 0);
      chk("async_event", ev0, 0);
      chk("async_dir", dir0, 0);
      chk("async_lim", lim0, 1);
      chk("async_count_min2", cnt2, 2);
      #1 rst_n = 1'b1;
      snap = pulses;
      repeat (6) tick();
      chk("post_rst_event6", ev0, 0);
      tick();
      chk("post_rst_event7", ev0, 1);
      chk("post_rst_count7", cnt0, 0);
      tick();
      chk("post_rst_step", sp0, 1);
      chk("post_rst_down_wrap", cnt0, 255);
      chk("post_rst_down_sat", cnt1, 0);
      repeat (10) tick();
      chk("post_rst_one_step", pulses - snap, 1);
      chk("post_rst_hold", cnt0, 255);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
